uart_pixel_loader: RTL
======================

// Module: uart_pixel_loader
// PURPOSE
//   Upstream stage of the grayscale pipeline. Pops bytes from the UART receive
//   FIFO and packs each R,G,B triple into one 24-bit pixel. Writes the pixels in
//   order into the image RAM that the grayscale/tx stage later reads.
//   Runs once per start pulse and fills NUM_PIXELS words from address 0.
// PARAMETERS
//   ADDR_BITS       13        width of the image RAM address
//   NUM_PIXELS      8192      pixels per frame; must be <= 2**ADDR_BITS
//   TIMEOUT_CYCLES  1000000   idle clocks allowed inside a partial pixel before it is dropped
//   TO_BITS         20        width of the timeout counter; 2**TO_BITS > TIMEOUT_CYCLES
// PORTS
//   clk          in   1          system clock, rising edge
//   reset        in   1          asynchronous, active-high reset
//   start        in   1          1-cycle pulse: begin loading a frame (ignored while busy)
//   rx_empty     in   1          UART rx FIFO empty; when 0, r_data is valid
//   r_data       in   8          UART rx FIFO head byte
//   rd_uart      out  1          pop strobe to UART rx FIFO, 1 cycle per byte
//   mem_we       out  1          RAM write enable
//   mem_addr     out  ADDR_BITS  RAM write address
//   mem_di       out  24         RAM write data {R,G,B}
//   busy         out  1          frame load in progress
//   done         out  1          frame complete; sticky until next start
//   timeout_err  out  1          sticky: a partial pixel was dropped this frame
// BEHAVIOUR
//   - Reset is asynchronous, active-high, and takes priority in every state. Reset
//     values: state=IDLE; rd_uart, mem_we, busy, done and timeout_err are 0;
//     mem_addr=0; mem_di=0; byte_idx=0; to_cnt=0.
//   - Reset mid-frame drops any partial pixel. RAM contents are left as written.
//   - FSM states: IDLE, RECV, WRITE, DONE. busy=1 in RECV and WRITE only.
//   - IDLE/DONE: rd_uart=0; the FIFO is not drained.
//       On start: clear mem_addr, byte_idx, done and timeout_err; go to RECV.
//   - RECV: rd_uart = !rx_empty (combinational, this state only).
//       In the same cycle, capture r_data into pix = {pix[15:0], r_data}.
//       The first byte is R and ends in [23:16]; the third byte is B and ends in [7:0].
//       Increment byte_idx on each pop. After the third pop, set byte_idx=0 and go to WRITE.
//   - WRITE: lasts exactly 1 cycle. mem_we=1, mem_di=pix, mem_addr=current address.
//       rd_uart=0.
//       If mem_addr==NUM_PIXELS-1: go to DONE, set done=1, and hold mem_addr.
//       Otherwise: mem_addr+1, back to RECV.
//   - Latency: the cycle after the third byte's pop cycle has mem_we=1.
//     Peak rate is 1 pixel per 4 cycles.
//   - mem_we is 0 outside WRITE. mem_di and mem_addr hold their values between writes.
//   - Timeout: to_cnt is cleared on every pop and whenever byte_idx==0. It increments
//     in RECV while rx_empty=1 and byte_idx!=0. When to_cnt reaches
//     TIMEOUT_CYCLES-1: byte_idx=0, pix is discarded, timeout_err=1, and the block
//     stays in RECV. mem_addr does not advance.
//   - A pop in the same cycle as the timeout terminal count: the pop wins, and the
//     byte counts as a normal byte.
//   - start in RECV/WRITE is ignored. start in DONE restarts at address 0.
//   - Address arithmetic is unsigned ADDR_BITS. It never wraps past NUM_PIXELS-1.
// TESTING
//   1. Reset mid-RECV with byte_idx=2 -> next cycle all outputs 0, state IDLE;
//      after start, a new triple 11,22,33 writes 24'h112233 at addr 0.
//   2. start; FIFO supplies AA,BB,CC back-to-back -> rd_uart high 3 cycles;
//      the next cycle has mem_we=1, mem_addr=0, mem_di=24'hAABBCC.
//   3. NUM_PIXELS=4, 12 bytes 00..0B -> writes 000102@0, 030405@1, 060708@2, 090A0B@3;
//      done=1 and busy=0 one cycle after the last write; no 5th write.
//   4. TIMEOUT_CYCLES=16: send 2 bytes, then stall 20 cycles, then DE,AD,BE
//      -> timeout_err=1; addr 0 gets 24'hDEADBE.
//   5. Bytes present in the FIFO while IDLE/DONE -> rd_uart stays 0 and no mem_we;
//      start pulsed during RECV -> no restart, mem_addr unchanged.
//   6. Random rx_empty gaps (1-50 cycles, all < timeout) over 8192 pixels ->
//      the RAM image matches the reference model, and timeout_err=0.

Source files
------------

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader
// Pulls bytes out of the UART receive FIFO, packs every R,G,B triple into a
// 24-bit pixel and writes the pixels in order into the image RAM, starting at
// address 0, until NUM_PIXELS words have been written. A partial pixel that
// sits idle for TIMEOUT_CYCLES clocks is thrown away so that a lost byte cannot
// permanently shift the colour channels of the rest of the frame.

module uart_pixel_loader #(
  parameter int ADDR_BITS      = 13,
  parameter int NUM_PIXELS     = 8192,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_BITS        = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_empty,
  input  logic [7:0]           r_data,
  output logic                 rd_uart,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [23:0]          mem_di,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  // Address of the final pixel of a frame; the write there ends the frame.
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PIXELS - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  // Terminal count of the idle counter inside a partial pixel.
  localparam logic [TO_BITS-1:0]   TO_LAST   = TO_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_BITS-1:0]   TO_ONE    = TO_BITS'(1);

  // Index of the byte that completes a pixel (B channel).
  localparam logic [1:0]           LAST_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
  logic [23:0]          pix_q, pix_d;
  logic [23:0]          mem_di_q, mem_di_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 pop;
  logic [23:0]          pix_shift;

  // A byte is consumed in any RECV cycle where the FIFO has data; the pop
  // strobe must be combinational so the FIFO advances in that same cycle.
  assign pop       = (state_q == RECV) && !rx_empty;
  assign pix_shift = {pix_q[15:0], r_data};

  assign rd_uart     = pop;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_di      = mem_di_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

  // Next-state logic: frame sequencing, byte packing, idle timeout and the
  // registered RAM write port, which is loaded one cycle ahead of WRITE.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    to_cnt_d      = to_cnt_q;
    pix_d         = pix_q;
    mem_di_d      = mem_di_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RECV;
          mem_addr_d    = '0;
          byte_idx_d    = '0;
          to_cnt_d      = '0;
          done_d        = 1'b0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
        end
      end

      RECV: begin
        if (pop) begin
          // A pop always counts as a real byte, even on the timeout terminal count.
          pix_d    = pix_shift;
          to_cnt_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            mem_we_d   = 1'b1;
            mem_di_d   = pix_shift;
            state_d    = WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (byte_idx_q == 2'd0) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          // Stale partial pixel: drop it and resynchronise on the next byte as R.
          byte_idx_d    = '0;
          to_cnt_d      = '0;
          pix_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end

      WRITE: begin
        if (mem_addr_q == LAST_ADDR) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_ONE;
          state_d    = RECV;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      to_cnt_q      <= '0;
      pix_q         <= '0;
      mem_di_q      <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      to_cnt_q      <= to_cnt_d;
      pix_q         <= pix_d;
      mem_di_q      <= mem_di_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
